// File: rtl/sync_async_hs_tx_if.sv
// Bundle of the synchronous upstream port and the async bundled-data channel
// for sync_async_hs_tx. The master side is the environment (word source plus
// channel acknowledger); the slave side is the transmitter.
interface sync_async_hs_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              req_o;
  logic              ack_i;
  logic [DATA_W-1:0] data_o;

  modport master (
    output in_valid, in_data, ack_i,
    input  in_ready, req_o, data_o
  );

  modport slave (
    input  in_valid, in_data, ack_i,
    output in_ready, req_o, data_o
  );
endinterface

// File: rtl/sync_async_hs_tx.sv
// sync_async_hs_tx: clocked 4-phase bundled-data transmitter.
// Takes words on a valid/ready port and drives req/data into a self-timed
// channel, synchronising the returning ack and completing the full
// return-to-zero cycle before the next word is accepted.
// Optional feature macro: ACK_TIMEOUT_EN (sticky per-phase ack timeout flag).
module sync_async_hs_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  sync_async_hs_tx_if.slave  bus,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_req;
  logic                   w_req_nxt;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      w_data_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ack_s;
  logic                   w_in_ready;
  logic                   w_xfer;

  // Ack synchroniser; the FSM only ever looks at the last stage
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_i};
  end

  assign w_ack_s    = r_sync[SYNC_STAGES-1];
  assign w_in_ready = (r_state == S_IDLE) & ~w_ack_s & ~rst;
  assign w_xfer     = bus.in_valid & w_in_ready;

  // State, req and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic: capture in IDLE, one setup cycle, then the 4 phases
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_data_nxt  = bus.in_data;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_req_nxt   = 1'b1;
        w_state_nxt = S_REQ_HI;
      end
      S_REQ_HI: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (!w_ack_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready = w_in_ready;
  assign bus.req_o    = r_req;
  assign bus.data_o   = r_data;
  assign busy         = (r_state != S_IDLE);

`ifdef ACK_TIMEOUT_EN
  localparam int                CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LP_TMO  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LP_TMO1 = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;
  logic             w_wait_ph;

  assign w_wait_ph = (r_state == S_REQ_HI) || (r_state == S_REQ_LO);

  // Phase timer: any state change clears it, which covers both entries into
  // the waiting phases; a transition on the would-be timeout edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_wait_ph) begin
      if (r_cnt != LP_TMO)  r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == LP_TMO1) r_tmo <= 1'b1;
    end
  end

  assign timeout_err = r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
  assign timeout_err  = 1'b0;
`endif

endmodule
